// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO with a launch FSM that feeds async_transmitter.
// Producers can push bursts of bytes with a single-cycle write strobe. The FSM
// then pops them one at a time into the transmitter's start/data/busy handshake.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   wr_en     write strobe, one byte per cycle while high
//   wr_data   byte to enqueue
//   full      FIFO holds DEPTH entries
//   empty     FIFO holds no entries
//   count     current occupancy, 0..DEPTH
//   overflow  one-cycle pulse after a write was dropped because the FIFO was full
//   tx_busy   TxD_busy from async_transmitter
//   tx_start  TxD_start to async_transmitter, one-cycle pulse
//   tx_data   TxD_data to async_transmitter, held from tx_start until the next pop
module uart_tx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count,
  output logic            overflow,
  input  logic            tx_busy,
  output logic            tx_start,
  output logic [7:0]      tx_data
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLaunch   = 2'd1,
    StWaitBusy = 2'd2,
    StWaitDone = 2'd3
  } state_e;

  localparam logic [ADDR_W:0]   CountFull = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CountOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q;
  logic [7:0]        tx_data_q;
  state_e            state_q, state_d;

  logic wr_accept;
  logic wr_reject;
  logic pop;

  // Flags decode the registered count, so a write into an empty FIFO is not
  // visible to the launcher until the following cycle.
  assign full     = (count_q == CountFull);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_data  = tx_data_q;
  assign tx_start = (state_q == StLaunch);

  // A write while full is dropped even if a pop frees a slot in the same cycle.
  assign wr_accept = wr_en && !full;
  assign wr_reject = wr_en && full;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        // The busy guard also keeps us from launching over a frame that the
        // transmitter is still finishing after our own reset.
        if (!empty && !tx_busy) begin
          pop     = 1'b1;
          state_d = StLaunch;
        end
      end
      StLaunch:   state_d = StWaitBusy;
      StWaitBusy: if (tx_busy) state_d = StWaitDone;
      StWaitDone: if (!tx_busy) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (wr_accept && !pop) begin
      count_d = count_q + CountOne;
    end else if (!wr_accept && pop) begin
      count_d = count_q - CountOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= wr_reject;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      if (wr_accept) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q <= 8'h00;
    end else if (pop) begin
      tx_data_q <= mem_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_en;
  logic [7:0]      wr_data;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            overflow;
  logic            tx_busy;
  logic            tx_start;
  logic [7:0]      tx_data;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: byte queue plus a description of the launch timing.
  logic [7:0] m_q[$];
  logic [7:0] m_accepted[$];
  logic [7:0] m_txd;
  bit         m_ovf;
  bit         m_launch;     // tx_start is due in the current cycle
  bit         m_in_flight;  // frame launched, transmitter not yet done
  bit         m_busy_seen;

  // Transmitter model: busy for busy_len cycles starting one after tx_start.
  int  busy_left  = 0;
  int  busy_len   = 4;
  bit  force_busy = 1'b0;

  logic [7:0] got[$];
  int         peak;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_txd       = 8'h00;
    m_ovf       = 1'b0;
    m_launch    = 1'b0;
    m_in_flight = 1'b0;
    m_busy_seen = 1'b0;
  endtask

  task automatic check_outputs();
    check_eq("count", 32'(count), 32'(m_q.size()));
    check_eq("empty", 32'(empty), 32'(m_q.size() == 0));
    check_eq("full", 32'(full), 32'(m_q.size() == DEPTH));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("tx_start", 32'(tx_start), 32'(m_launch));
    check_eq("tx_data", 32'(tx_data), 32'(m_txd));
  endtask

  task automatic step(input bit wr, input logic [7:0] d);
    bit acc;
    bit do_pop;
    bit exp_start;
    wr_en   = wr;
    wr_data = d;
    tx_busy = force_busy || (busy_left > 0);
    @(negedge clk);
    check_outputs();
    if (tx_start) got.push_back(tx_data);
    if (int'(count) > peak) peak = int'(count);
    exp_start = m_launch;
    acc       = wr && (m_q.size() < DEPTH);
    do_pop    = !m_launch && !m_in_flight && (m_q.size() > 0) && !tx_busy;
    m_ovf     = wr && !acc;
    if (m_in_flight) begin
      if (m_busy_seen && !tx_busy) m_in_flight = 1'b0;
      else if (tx_busy) m_busy_seen = 1'b1;
    end
    if (m_launch) begin
      m_in_flight = 1'b1;
      m_busy_seen = 1'b0;
    end
    m_launch = do_pop;
    if (do_pop) m_txd = m_q.pop_front();
    if (acc) begin
      m_q.push_back(d);
      m_accepted.push_back(d);
    end
    if (exp_start) busy_left = busy_len;
    else if (busy_left > 0) busy_left--;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    wr_en = 1'b0;
    model_clear();
    for (int i = 0; i < cycles; i++) begin
      tx_busy = force_busy || (busy_left > 0);
      @(negedge clk);
      check_outputs();
      if (busy_left > 0) busy_left--;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4000; i++) begin
      if (m_q.size() == 0 && !m_launch && !m_in_flight && busy_left == 0) break;
      step(1'b0, 8'h00);
    end
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    check_eq("drain_empty", 32'(empty), 32'd1);
  endtask

  task automatic check_list(input string tag, input logic [7:0] want[$]);
    check_eq({tag, "_len"}, 32'(got.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < got.size(); i++) begin
      check_eq($sformatf("%s_%0d", tag, i), 32'(got[i]), 32'(want[i]));
    end
  endtask

  logic [7:0] want[$];

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    tx_busy = 1'b0;

    apply_reset(3);

    // Single byte: start two cycles after the write.
    got.delete();
    busy_len = 4;
    step(1'b1, 8'hA5);
    step(1'b0, 8'h00);
    check_eq("single_pop_cnt", 32'(count), 32'd0);
    step(1'b0, 8'h00);
    drain();
    want = {8'hA5};
    check_list("single", want);

    // Burst with a 20-cycle transmitter.
    got.delete();
    peak     = 0;
    busy_len = 20;
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i));
    drain();
    check_eq("burst_peak", 32'(peak), 32'd4);
    want.delete();
    for (int i = 1; i <= 5; i++) want.push_back(8'(i));
    check_list("burst", want);

    // Fill to full with the transmitter held busy, then one overflow.
    got.delete();
    busy_len   = 3;
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'(8'h10 + i));
      if (i == 15) check_eq("full_after_16", 32'(full), 32'd1);
    end
    check_eq("ovf_pulse", 32'(overflow), 32'd1);
    check_eq("ovf_count", 32'(count), 32'd16);
    step(1'b0, 8'h00);
    check_eq("ovf_clear", 32'(overflow), 32'd0);
    force_busy = 1'b0;
    drain();
    want.delete();
    for (int i = 0; i < 16; i++) want.push_back(8'(8'h10 + i));
    check_list("full", want);

    // Wrap-around: three rounds of 12.
    got.delete();
    peak     = 0;
    busy_len = 2;
    want.delete();
    for (int r = 0; r < 3; r++) begin
      force_busy = 1'b1;
      for (int i = 0; i < 12; i++) begin
        step(1'b1, 8'(8'h80 + r * 12 + i));
        want.push_back(8'(8'h80 + r * 12 + i));
      end
      force_busy = 1'b0;
      drain();
    end
    check_eq("wrap_peak", 32'(peak), 32'd12);
    check_list("wrap", want);

    // Simultaneous write and pop at count 5.
    got.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i));
    step(1'b0, 8'h00);
    force_busy = 1'b0;
    step(1'b1, 8'h65);
    check_eq("simul_count", 32'(count), 32'd5);
    drain();
    want.delete();
    for (int i = 0; i < 6; i++) want.push_back(8'(8'h60 + i));
    check_list("simul", want);

    // Reset mid-operation with the transmitter still busy.
    busy_len   = 20;
    force_busy = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i));
    got.delete();
    apply_reset(2);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h3C);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
    check_eq("rst_no_launch", 32'(got.size()), 32'd0);
    force_busy = 1'b0;
    drain();
    want = {8'h3C};
    check_list("rst", want);

    // Randomized traffic against the model.
    got.delete();
    m_accepted.delete();
    for (int c = 0; c < 3000; c++) begin
      busy_len   = int'($urandom_range(1, 8));
      force_busy = ($urandom_range(0, 15) == 0);
      step(1'($urandom_range(0, 1)), 8'($urandom));
    end
    force_busy = 1'b0;
    drain();
    check_list("rand", m_accepted);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
